dram_responder: RTL and testbench

//  Data-memory responder on the core's load/store port (the far end of the ram_req/ram_we bus).

---
 rtl/dram_responder.sv | 209 ++++++++++++++++++++
 tb/tb_dram_responder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_responder.sv
// ---------------------------------------------------------------------------------------------
// dram_responder
//
// Data-memory responder on the core's load/store port. It services zero-wait word reads and
// writes into an on-chip RAM array and a small MMIO block. The core has no ready/ack, so reads
// are answered combinationally in the request cycle and writes commit at the next rising edge.
//
// MMIO block (4 KiB window at MMIO_BASE), byte offsets:
//   0x00 MTIME_LO  RO  mtime[31:0]
//   0x04 MTIME_HI  RO  mtime[63:32]
//   0x08 MTIMECMP  RW  32-bit compare value
//   0x0C CTRL      RW  bit0 EN, bit1 PEND (write 1 clears); other bits read 0
//   0x10 TOHOST    WO  first write latches tohost and raises halt; reads 0
//   Other offsets read 0 and ignore writes.
//
// Build option: define DRAM_TIMER_EN to implement the timer (MTIME, MTIMECMP, CTRL). Without it
// there are no timer flops, offsets 0x00-0x0C read 0 and ignore writes, and timer_irq_o is 0.
//
// Ports:
//   clk_i        in   1     clock, rising edge
//   rst_i        in   1     asynchronous reset, active low
//   ram_req_i    in   1     access request, one cycle per access
//   ram_we_i     in   1     1 = write, 0 = read (qualified by ram_req_i)
//   ram_addr_i   in   XLEN  byte address, bits [1:0] ignored
//   ram_wdata_i  in   XLEN  write data
//   ram_data_o   out  XLEN  read data, combinational; 0 when idle, on writes and unmapped reads
//   timer_irq_o  out  1     timer interrupt level (EN & PEND)
//   halt_o       out  1     sticky, set by the first TOHOST write
//   tohost_o     out  XLEN  value of the first TOHOST write
//   bus_err_o    out  1     sticky, set by any access that hits no mapped region
// ---------------------------------------------------------------------------------------------

`ifndef XLEN
`define XLEN 32
`endif

module dram_responder #(
  parameter int unsigned     XLEN       = `XLEN,
  parameter int unsigned     DEPTH_LOG2 = 12,
  parameter logic [XLEN-1:0] RAM_BASE   = 32'h0000_0000,
  parameter logic [XLEN-1:0] MMIO_BASE  = 32'hF000_0000
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            ram_req_i,
  input  logic            ram_we_i,
  input  logic [XLEN-1:0] ram_addr_i,
  input  logic [XLEN-1:0] ram_wdata_i,
  output logic [XLEN-1:0] ram_data_o,
  output logic            timer_irq_o,
  output logic            halt_o,
  output logic [XLEN-1:0] tohost_o,
  output logic            bus_err_o
);

  localparam int unsigned     Depth    = 2 ** DEPTH_LOG2;
  localparam logic [XLEN-1:0] RamBytes = XLEN'(4 * Depth);

  // MMIO word offsets (byte offset >> 2)
  localparam logic [9:0] WordTohost = 10'h004;
`ifdef DRAM_TIMER_EN
  localparam logic [9:0] WordMtimeLo  = 10'h000;
  localparam logic [9:0] WordMtimeHi  = 10'h001;
  localparam logic [9:0] WordMtimecmp = 10'h002;
  localparam logic [9:0] WordCtrl     = 10'h003;
`endif

  // -------------------------------------------------------------------------------------------
  // Address decode
  // -------------------------------------------------------------------------------------------
  logic [XLEN-1:0]       ram_off;
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic [9:0]            mmio_word;
  logic                  ram_hit;
  logic                  mmio_hit;
  logic                  unmapped;
  logic                  rd_req;
  logic                  wr_ram;
  logic                  wr_mmio;

  // The subtraction wraps for addresses below RAM_BASE, so a single unsigned compare covers
  // both ends of the window.
  assign ram_off   = ram_addr_i - RAM_BASE;
  assign ram_hit   = (ram_off < RamBytes);
  assign ram_idx   = ram_off[DEPTH_LOG2+1:2];
  assign mmio_hit  = (ram_addr_i[XLEN-1:12] == MMIO_BASE[XLEN-1:12]);
  assign mmio_word = ram_addr_i[11:2];
  assign unmapped  = !ram_hit && !mmio_hit;

  assign rd_req  = ram_req_i && !ram_we_i;
  assign wr_ram  = ram_req_i && ram_we_i && ram_hit;
  assign wr_mmio = ram_req_i && ram_we_i && mmio_hit && !ram_hit;

  logic unused_bits;
  assign unused_bits = ^{ram_off[1:0]};

  // -------------------------------------------------------------------------------------------
  // RAM array
  // -------------------------------------------------------------------------------------------
  logic [XLEN-1:0] mem [Depth];

  // Contents are not cleared by reset; the reset branch only blocks a write that would
  // otherwise land on an edge while reset is held.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      // contents retained
    end else if (wr_ram) begin
      mem[ram_idx] <= ram_wdata_i;
    end
  end

  // -------------------------------------------------------------------------------------------
  // TOHOST / halt / bus error
  // -------------------------------------------------------------------------------------------
  logic            halt_q;
  logic [XLEN-1:0] tohost_q;
  logic            bus_err_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      halt_q    <= 1'b0;
      tohost_q  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      if (ram_req_i && unmapped) begin
        bus_err_q <= 1'b1;
      end
      // Only the first TOHOST write counts; later ones leave the latched value alone.
      if (wr_mmio && (mmio_word == WordTohost) && !halt_q) begin
        halt_q   <= 1'b1;
        tohost_q <= ram_wdata_i;
      end
    end
  end

  assign halt_o    = halt_q;
  assign tohost_o  = tohost_q;
  assign bus_err_o = bus_err_q;

  // -------------------------------------------------------------------------------------------
  // Timer
  // -------------------------------------------------------------------------------------------
  logic [XLEN-1:0] mmio_rdata;

`ifdef DRAM_TIMER_EN
  logic [63:0] mtime_q;
  logic [31:0] mtimecmp_q;
  logic        en_q;
  logic        pend_q;
  logic        wr_ctrl;
  logic        pend_set;
  logic        pend_clr;

  assign wr_ctrl  = wr_mmio && (mmio_word == WordCtrl);
  assign pend_set = en_q && (mtime_q[31:0] >= mtimecmp_q);
  assign pend_clr = wr_ctrl && ram_wdata_i[1];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mtime_q    <= '0;
      mtimecmp_q <= 32'hFFFF_FFFF;
      en_q       <= 1'b0;
      pend_q     <= 1'b0;
    end else begin
      mtime_q <= mtime_q + 64'd1;
      if (wr_mmio && (mmio_word == WordMtimecmp)) begin
        mtimecmp_q <= ram_wdata_i[31:0];
      end
      if (wr_ctrl) begin
        en_q <= ram_wdata_i[0];
      end
      // A set in the same cycle as a write-1-clear takes priority.
      pend_q <= pend_set || (pend_q && !pend_clr);
    end
  end

  // Pure function of two flops: no combinational path from the bus to the interrupt.
  assign timer_irq_o = en_q && pend_q;

  always_comb begin
    mmio_rdata = '0;
    case (mmio_word)
      WordMtimeLo:  mmio_rdata = XLEN'(mtime_q[31:0]);
      WordMtimeHi:  mmio_rdata = XLEN'(mtime_q[63:32]);
      WordMtimecmp: mmio_rdata = XLEN'(mtimecmp_q);
      WordCtrl:     mmio_rdata = XLEN'({pend_q, en_q});
      default:      mmio_rdata = '0;
    endcase
  end
`else
  assign timer_irq_o = 1'b0;
  assign mmio_rdata  = '0;
`endif

  // -------------------------------------------------------------------------------------------
  // Read data: zero-latency, and 0 whenever the cycle is not a mapped read.
  // -------------------------------------------------------------------------------------------
  always_comb begin
    ram_data_o = '0;
    if (rd_req) begin
      if (ram_hit) begin
        ram_data_o = mem[ram_idx];
      end else if (mmio_hit) begin
        ram_data_o = mmio_rdata;
      end
    end
  end

endmodule

// File: tb/tb_dram_responder.sv
// Self-checking bench for dram_responder: a directed vector table, hand-written timer, TOHOST,
// bus-error and reset sequences, then randomized traffic against a behavioural model.
module tb_dram_responder;

  localparam logic [31:0] Mmio = 32'hF000_0000;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ram_req_i = 1'b0;
  logic        ram_we_i = 1'b0;
  logic [31:0] ram_addr_i = '0;
  logic [31:0] ram_wdata_i = '0;
  logic [31:0] ram_data_o;
  logic        timer_irq_o;
  logic        halt_o;
  logic [31:0] tohost_o;
  logic        bus_err_o;

  dram_responder dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .ram_req_i   (ram_req_i),
    .ram_we_i    (ram_we_i),
    .ram_addr_i  (ram_addr_i),
    .ram_wdata_i (ram_wdata_i),
    .ram_data_o  (ram_data_o),
    .timer_irq_o (timer_irq_o),
    .halt_o      (halt_o),
    .tohost_o    (tohost_o),
    .bus_err_o   (bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_pass   = 0;
  logic s_irq;
  logic s_berr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, {31'b0, act}, {31'b0, exp});
  endtask

  // One bus access: drive at the falling edge, sample just after, commit at the rising edge.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata);
    @(negedge clk_i);
    ram_req_i   = 1'b1;
    ram_we_i    = we;
    ram_addr_i  = addr;
    ram_wdata_i = wdata;
    #1;
    rdata  = ram_data_o;
    s_irq  = timer_irq_o;
    s_berr = bus_err_o;
    @(posedge clk_i);
    #1;
    ram_req_i = 1'b0;
    ram_we_i  = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #2 rst_i = 1'b1;
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[14];

  // Behavioural model state for the random phase
  logic [31:0] ref_mem [int];
  logic        m_halt;
  logic [31:0] m_tohost;
  logic        m_berr;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp;
    logic        we;
    logic        known;
    int unsigned kind;
    int          idx;

    vecs[0]  = '{1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0};
    vecs[1]  = '{1'b0, 32'h0000_0040, 32'h0,         32'hDEAD_BEEF};
    vecs[2]  = '{1'b1, 32'h0000_0040, 32'h1111_1111, 32'h0};
    vecs[3]  = '{1'b0, 32'h0000_0040, 32'h0,         32'h1111_1111};
    vecs[4]  = '{1'b1, 32'h0000_0040, 32'h0000_0022, 32'h0};
    vecs[5]  = '{1'b0, 32'h0000_0040, 32'h0,         32'h0000_0022};
    vecs[6]  = '{1'b1, 32'h0000_3FFC, 32'hA5A5_A5A5, 32'h0};
    vecs[7]  = '{1'b0, 32'h0000_3FFC, 32'h0,         32'hA5A5_A5A5};
    vecs[8]  = '{1'b1, 32'h0000_0000, 32'h1234_5678, 32'h0};
    vecs[9]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h1234_5678};
    vecs[10] = '{1'b0, 32'h0000_3FFE, 32'h0,         32'hA5A5_A5A5};
    vecs[11] = '{1'b0, 32'h0000_0043, 32'h0,         32'h0000_0022};
    vecs[12] = '{1'b0, Mmio + 32'h10, 32'h0,         32'h0};
    vecs[13] = '{1'b0, Mmio + 32'h20, 32'h0,         32'h0};

    // Power-on reset
    #1 rst_i = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check_bit("rst halt", halt_o, 1'b0);
    check("rst tohost", tohost_o, 32'h0);
    check_bit("rst bus_err", bus_err_o, 1'b0);
    check_bit("rst irq", timer_irq_o, 1'b0);
    check("rst rdata idle", ram_data_o, 32'h0);
    #1 rst_i = 1'b1;

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      access(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd);
      check($sformatf("vec%0d rdata", i), rd, vecs[i].exp);
    end
    check_bit("vec bus_err clear", bus_err_o, 1'b0);

    // TOHOST: first write wins
    check_bit("tohost halt before", halt_o, 1'b0);
    access(1'b1, Mmio + 32'h10, 32'h1, rd);
    access(1'b1, Mmio + 32'h10, 32'h5, rd);
    check_bit("tohost halt", halt_o, 1'b1);
    check("tohost value", tohost_o, 32'h1);
    access(1'b0, 32'h0000_0040, 32'h0, rd);
    check("ram after halt", rd, 32'h0000_0022);

    // Timer
    do_reset();
    check_bit("halt cleared by reset", halt_o, 1'b0);
`ifdef DRAM_TIMER_EN
    access(1'b0, Mmio + 32'h0, 32'h0, rd);
    check("mtime lo at 0", rd, 32'd0);
    access(1'b0, Mmio + 32'h0, 32'h0, rd);
    check("mtime lo at 1", rd, 32'd1);
    access(1'b0, Mmio + 32'h4, 32'h0, rd);
    check("mtime hi", rd, 32'd0);
    access(1'b0, Mmio + 32'h8, 32'h0, rd);
    check("mtimecmp reset", rd, 32'hFFFF_FFFF);
    access(1'b0, Mmio + 32'hC, 32'h0, rd);
    check("ctrl reset", rd, 32'h0);
    access(1'b1, Mmio + 32'h8, 32'd20, rd);
    access(1'b1, Mmio + 32'hC, 32'h1, rd);
    // irq visible once a cycle with mtime >= 20 has been clocked
    for (int k = 0; k < 25; k++) begin
      access(1'b0, Mmio + 32'h0, 32'h0, rd);
      check_bit($sformatf("irq at mtime %0d", rd), s_irq, rd >= 32'd21);
    end
    access(1'b1, Mmio + 32'hC, 32'h3, rd);
    check_bit("irq set wins over w1c", timer_irq_o, 1'b1);
    access(1'b1, Mmio + 32'h8, 32'hFFFF_FFFF, rd);
    access(1'b1, Mmio + 32'hC, 32'h3, rd);
    check_bit("irq cleared", timer_irq_o, 1'b0);
    access(1'b0, Mmio + 32'hC, 32'h0, rd);
    check("ctrl en only", rd, 32'h1);
    access(1'b0, Mmio + 32'h8, 32'h0, rd);
    check("mtimecmp readback", rd, 32'hFFFF_FFFF);
    // Clearing EN masks the irq but PEND survives
    access(1'b1, Mmio + 32'h8, 32'h0, rd);
    access(1'b1, Mmio + 32'hC, 32'h0, rd);
    check_bit("irq masked", timer_irq_o, 1'b0);
    access(1'b0, Mmio + 32'hC, 32'h0, rd);
    check("ctrl pend kept", rd, 32'h2);
`else
    access(1'b0, Mmio + 32'h0, 32'h0, rd);
    check("mtime lo absent", rd, 32'h0);
    access(1'b1, Mmio + 32'h8, 32'h0, rd);
    access(1'b1, Mmio + 32'hC, 32'h3, rd);
    repeat (5) @(posedge clk_i);
    access(1'b0, Mmio + 32'h0, 32'h0, rd);
    check("mtime lo still 0", rd, 32'h0);
    access(1'b0, Mmio + 32'hC, 32'h0, rd);
    check("ctrl absent", rd, 32'h0);
    access(1'b0, Mmio + 32'h8, 32'h0, rd);
    check("mtimecmp absent", rd, 32'h0);
    check_bit("irq tied low", timer_irq_o, 1'b0);
`endif
    check_bit("timer regs no bus_err", bus_err_o, 1'b0);

    // Unmapped access
    access(1'b0, 32'h8000_0000, 32'h0, rd);
    check("unmapped rdata", rd, 32'h0);
    check_bit("bus_err not yet", s_berr, 1'b0);
    check_bit("bus_err set", bus_err_o, 1'b1);
    access(1'b1, 32'h8000_0040, 32'h9999_9999, rd);
    access(1'b1, 32'h0000_4000, 32'h8888_8888, rd);
    access(1'b0, 32'h0000_0040, 32'h0, rd);
    check("ram untouched by unmapped", rd, 32'h0000_0022);
    access(1'b0, 32'h0000_0000, 32'h0, rd);
    check("ram word0 untouched", rd, 32'h1234_5678);
    check_bit("bus_err sticky", bus_err_o, 1'b1);

    // Randomized traffic against the model
    do_reset();
    m_halt = 1'b0;
    m_tohost = 32'h0;
    m_berr = 1'b0;
    for (int i = 0; i < 250; i++) begin
      kind  = $urandom_range(0, 31);
      we    = 1'($urandom_range(0, 1));
      wd    = $urandom;
      exp   = 32'h0;
      known = 1'b1;
      idx   = 0;
      if (kind < 26) begin
        idx = 64 + int'($urandom_range(0, 15));
        a   = 32'(idx * 4) + 32'($urandom_range(0, 3));
        if (!we) begin
          if (ref_mem.exists(idx)) exp = ref_mem[idx];
          else known = 1'b0;
        end
      end else if (kind < 28) begin
        if (kind == 26) a = 32'h0000_4000 + ($urandom % 32'hEFFF_C000);
        else a = 32'hF000_1000 + ($urandom % 32'h0FFF_F000);
      end else if (kind == 28) begin
        a = Mmio + 32'h10;
      end else begin
        a = Mmio + 32'h14 + 32'(4 * $urandom_range(0, 1018));
      end

      access(we, a, wd, rd);
      if (known) check($sformatf("rand%0d rdata @%h", i, a), rd, exp);

      if (kind < 26 && we) ref_mem[idx] = wd;
      if (kind == 26 || kind == 27) m_berr = 1'b1;
      if (kind == 28 && we && !m_halt) begin
        m_halt = 1'b1;
        m_tohost = wd;
      end
      check_bit($sformatf("rand%0d bus_err", i), bus_err_o, m_berr);
      check_bit($sformatf("rand%0d halt", i), halt_o, m_halt);
      check($sformatf("rand%0d tohost", i), tohost_o, m_tohost);
    end

    // Reset dropped in the middle of a write
    access(1'b1, 32'h0000_0080, 32'hCAFE_0000, rd);
    access(1'b1, Mmio + 32'h10, 32'h7, rd);
    access(1'b0, 32'h9000_0000, 32'h0, rd);
`ifdef DRAM_TIMER_EN
    access(1'b1, Mmio + 32'h8, 32'h0, rd);
    access(1'b1, Mmio + 32'hC, 32'h1, rd);
    repeat (3) @(posedge clk_i);
    #1 check_bit("irq before reset", timer_irq_o, 1'b1);
`endif
    check_bit("halt before reset", halt_o, 1'b1);
    check_bit("bus_err before reset", bus_err_o, 1'b1);
    @(negedge clk_i);
    ram_req_i   = 1'b1;
    ram_we_i    = 1'b1;
    ram_addr_i  = 32'h0000_0080;
    ram_wdata_i = 32'hBAD0_BAD0;
    #1 rst_i = 1'b0;
    #1;
    check_bit("midrst halt", halt_o, 1'b0);
    check("midrst tohost", tohost_o, 32'h0);
    check_bit("midrst bus_err", bus_err_o, 1'b0);
    check_bit("midrst irq", timer_irq_o, 1'b0);
    @(posedge clk_i);
    #1;
    ram_req_i = 1'b0;
    ram_we_i  = 1'b0;
    #1 rst_i = 1'b1;
`ifdef DRAM_TIMER_EN
    access(1'b0, Mmio + 32'h0, 32'h0, rd);
    check("mtime restarts", rd, 32'd0);
`endif
    access(1'b0, 32'h0000_0080, 32'h0, rd);
    check("write dropped by reset", rd, 32'hCAFE_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
